timex_pager: RTL
================

TIMEX_PAGER -- requirements
Module: timex_pager

Interface
REQ-001 SHALL have parameter NUM_TRAPS, default 2: number of page-in trap addresses (1..8).
REQ-002 SHALL have parameter TRAP_ADDRS, default {16'h0008,16'h0000}: packed NUM_TRAPS x 16-bit trap addresses, entry 0 in LSBs.
REQ-003 SHALL have parameter PAGEOUT_ADDR, default 16'h0604: page-out address; must differ from every trap.
REQ-004 SHALL have parameters ROM_AW (12) and RAM_AW (11): address widths of the interface ROM and RAM windows.
REQ-005 SHALL have parameter RAM_BASE, default 16'h2000: RAM window base, aligned to 2^RAM_AW.
REQ-006 SHALL have parameters FDD_PORT (8'hEF) and CTRL_PORT (8'hEB): I/O port numbers for FDD data and the control/status register.
REQ-007 SHALL have ports: CLK in 1 system clock (Z80 clock or faster); RST in 1 reset, asynchronous, active-high.
REQ-008 SHALL have ports: A in 16 address bus; D_IN in 8 data bus; nIORQ, nMREQ, nRD, nWR, nM1 in 1 each, Z80 strobes, active-low.
REQ-009 SHALL have ports: D_OUT out 8 status byte; D_OE out 1 status drive enable, active-high.
REQ-010 SHALL have ports: nZX_ROMCS out 1 (high disables internal ROM); nROM_CS, nRAM_CS, nRAM_WE out 1, active-low.
REQ-011 SHALL have ports: LS273 out 1 FDD write strobe, active-high; nLS244 out 1 FDD read strobe, active-low; PAGED out 1 state indicator.

Function
REQ-012 Each of nMREQ, nIORQ, nRD, nWR, nM1 SHALL pass a 2-flop synchroniser; A and D_IN SHALL be registered alongside the second stage.
REQ-013 Edge detects SHALL use the synchronised signals; event latency is 3 CLK from pin edge to state change.
REQ-014 State machine SHALL have states OFF, ON, EXITING; PAGED = (state != OFF).
REQ-015 OFF->ON on nMREQ falling edge with nM1=0, nRD=0, A equal to any TRAP_ADDRS entry, and TRAPS_DIS=0.
REQ-016 ON->EXITING on nMREQ falling edge with nRD=0 and A==PAGEOUT_ADDR, with or without M1.
REQ-017 EXITING->OFF on the following synchronised nMREQ rising edge, so the byte at PAGEOUT_ADDR is still read from interface ROM.
REQ-018 A control write SHALL fire on nWR falling edge with nIORQ=0, nM1=1 and A[7:0]==CTRL_PORT; D_IN bits: 0 FORCE_IN, 1 FORCE_OUT, 2 WP, 3 TRAPS_DIS.
REQ-019 FORCE_IN=1, FORCE_OUT=0 -> ON from any state; FORCE_OUT=1, FORCE_IN=0 -> OFF from any state; both or neither -> state unchanged; WP and TRAPS_DIS are loaded on every control write.
REQ-020 A control-write event SHALL take priority over a memory event detected in the same CLK.
REQ-021 A trap fetch while ON or EXITING SHALL not change state but SHALL still increment the counter.
REQ-022 A 4-bit page-in counter SHALL increment modulo 16 (15->0) on every trap match, including while ON, and on every FORCE_IN that enters ON; it SHALL not increment on a trap blocked by TRAPS_DIS.
REQ-023 D_OUT SHALL be {count[3:0], TRAPS_DIS, WP, state==EXITING, PAGED}; D_OE SHALL be combinational: ~nIORQ & ~nRD & nM1 & A[7:0]==CTRL_PORT.
REQ-024 nZX_ROMCS SHALL equal PAGED.
REQ-025 nROM_CS SHALL be low iff PAGED & ~nMREQ & A[15:ROM_AW]==0, using raw pins.
REQ-026 nRAM_CS SHALL be low iff PAGED & ~nMREQ & A[15:RAM_AW]==RAM_BASE[15:RAM_AW]; nRAM_WE SHALL be low iff nRAM_CS low & ~nWR & ~WP.
REQ-027 LS273 SHALL be ~nIORQ & ~nWR & nM1 & A[7:0]==FDD_PORT; nLS244 SHALL be ~(~nIORQ & ~nRD & nM1 & A[7:0]==FDD_PORT); both independent of PAGED.
REQ-028 Interrupt acknowledge (nIORQ=0 & nM1=0) SHALL assert no I/O strobe or control event.

Reset
REQ-029 RST high SHALL asynchronously force: state OFF, WP 0, TRAPS_DIS 0, count 0, all synchroniser and edge flops to 1 (inactive).
REQ-030 During and after reset, outputs SHALL be: PAGED=0, nZX_ROMCS=0, nROM_CS=1, nRAM_CS=1, nRAM_WE=1, D_OUT=8'h00; combinational strobes follow pins.
REQ-031 Reset mid-cycle SHALL abort any pending EXITING; a nMREQ edge straddling reset release SHALL be ignored.

Structure
REQ-032 Package timex_pkg SHALL hold the state enum, CTRL bit indices, and default port/address constants.
REQ-033 Sub-module timex_sync_edge (2-flop sync plus registered fall/rise pulses, reset-to-1) SHALL be instantiated once per strobe.

Verification
REQ-034 Reset, then M1 fetch at 16'h0008 -> PAGED=1 and nZX_ROMCS=1 within 3 CLK of the nMREQ fall; D_OUT=8'h11.
REQ-035 While ON, M1 fetch at 16'h0604 -> state EXITING (D_OUT[1]=1), nROM_CS low for that read, OFF after the nMREQ rise.
REQ-036 Write 8'h04 to port 8'hEB, then memory write at 16'h2100 while paged -> nRAM_CS=0, nRAM_WE=1; read at 16'h0FFF -> nROM_CS=0; read at 16'h1000 -> nROM_CS=1.
REQ-037 Write 8'h08 (TRAPS_DIS) to 8'hEB, then fetch at 16'h0000 -> PAGED stays 0, count unchanged; write 8'h01 -> PAGED=1, count+1.
REQ-038 Sixteen trap fetches -> count wraps to 0; I/O read at 8'hEF -> nLS244=0; I/O write at 8'hEF -> LS273=1; IORQ with M1 low at 8'hEF -> no strobes.
REQ-039 Assert RST while EXITING -> all outputs at reset values immediately; fetch at 16'h0000 after release -> ON.

Source files
------------

// File: rtl/timex_pkg.sv
// Shared types and default constants for the Timex-style interface pager.
package timex_pkg;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_ON      = 2'd1,
        ST_EXITING = 2'd2
    } pager_state_e;

    localparam int CTRL_FORCE_IN  = 0;
    localparam int CTRL_FORCE_OUT = 1;
    localparam int CTRL_WP        = 2;
    localparam int CTRL_TRAPS_DIS = 3;

    localparam logic [31:0] DEF_TRAP_ADDRS   = {16'h0008, 16'h0000};
    localparam logic [15:0] DEF_PAGEOUT_ADDR = 16'h0604;
    localparam int          DEF_ROM_AW       = 12;
    localparam int          DEF_RAM_AW       = 11;
    localparam logic [15:0] DEF_RAM_BASE     = 16'h2000;
    localparam logic [7:0]  DEF_FDD_PORT     = 8'hEF;
    localparam logic [7:0]  DEF_CTRL_PORT    = 8'hEB;

endpackage

// File: rtl/timex_sync_edge.sv
// Two-flop synchroniser for one active-low Z80 strobe, with registered
// single-cycle fall/rise pulses derived from the synchronised level.
module timex_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s,
    output logic fall,
    output logic rise
);

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       fall_q, fall_d;
    logic       rise_q, rise_d;
    logic [1:0] arm_q, arm_d;

    // Edges are only reported once the second stage holds a real pin sample,
    // so a level that changed while reset was held never looks like an edge.
    always_comb begin
        s1_d   = d;
        s2_d   = s1_q;
        arm_d  = {arm_q[0], 1'b1};
        fall_d = arm_q[1] & s2_q & ~s1_q;
        rise_d = arm_q[1] & ~s2_q & s1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            fall_q <= 1'b0;
            rise_q <= 1'b0;
            arm_q  <= 2'b00;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            fall_q <= fall_d;
            rise_q <= rise_d;
            arm_q  <= arm_d;
        end
    end

    assign s    = s2_q;
    assign fall = fall_q;
    assign rise = rise_q;

endmodule

// File: rtl/timex_pager.sv
// Interface ROM/RAM pager: traps Z80 opcode fetches to page the interface in,
// pages out after the page-out fetch, and decodes FDD and control I/O ports.
module timex_pager
    import timex_pkg::*;
#(
    parameter int                      NUM_TRAPS    = 2,
    parameter logic [NUM_TRAPS*16-1:0] TRAP_ADDRS   = DEF_TRAP_ADDRS,
    parameter logic [15:0]             PAGEOUT_ADDR = DEF_PAGEOUT_ADDR,
    parameter int                      ROM_AW       = DEF_ROM_AW,
    parameter int                      RAM_AW       = DEF_RAM_AW,
    parameter logic [15:0]             RAM_BASE     = DEF_RAM_BASE,
    parameter logic [7:0]              FDD_PORT     = DEF_FDD_PORT,
    parameter logic [7:0]              CTRL_PORT    = DEF_CTRL_PORT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] A,
    input  logic [7:0]  D_IN,
    input  logic        nIORQ,
    input  logic        nMREQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nM1,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    output logic        nZX_ROMCS,
    output logic        nROM_CS,
    output logic        nRAM_CS,
    output logic        nRAM_WE,
    output logic        LS273,
    output logic        nLS244,
    output logic        PAGED
);

    logic mreq_s, mreq_fall, mreq_rise;
    logic iorq_s, iorq_fall, iorq_rise;
    logic rd_s, rd_fall, rd_rise;
    logic wr_s, wr_fall, wr_rise;
    logic m1_s, m1_fall, m1_rise;

    timex_sync_edge u_sync_mreq (.clk(CLK), .rst(RST), .d(nMREQ), .s(mreq_s), .fall(mreq_fall), .rise(mreq_rise));
    timex_sync_edge u_sync_iorq (.clk(CLK), .rst(RST), .d(nIORQ), .s(iorq_s), .fall(iorq_fall), .rise(iorq_rise));
    timex_sync_edge u_sync_rd   (.clk(CLK), .rst(RST), .d(nRD),   .s(rd_s),   .fall(rd_fall),   .rise(rd_rise));
    timex_sync_edge u_sync_wr   (.clk(CLK), .rst(RST), .d(nWR),   .s(wr_s),   .fall(wr_fall),   .rise(wr_rise));
    timex_sync_edge u_sync_m1   (.clk(CLK), .rst(RST), .d(nM1),   .s(m1_s),   .fall(m1_fall),   .rise(m1_rise));

    // Address and data travel through two stages so they line up with s2.
    logic [15:0]  a1_q, a1_d, a2_q, a2_d;
    logic [7:0]   d1_q, d1_d, d2_q, d2_d;
    pager_state_e state_q, state_d;
    logic         wp_q, wp_d;
    logic         traps_dis_q, traps_dis_d;
    logic [3:0]   count_q, count_d;

    logic trap_addr;
    logic ctrl_wr;
    logic mem_rd_fall;
    logic trap_ev;
    logic pageout_ev;
    logic force_in;
    logic force_out;

    always_comb begin
        a1_d = A;
        a2_d = a1_q;
        d1_d = D_IN;
        d2_d = d1_q;
    end

    always_comb begin
        trap_addr = 1'b0;
        for (int i = 0; i < NUM_TRAPS; i++) begin
            if (a2_q == TRAP_ADDRS[i*16 +: 16]) trap_addr = 1'b1;
        end
    end

    assign ctrl_wr     = wr_fall & ~iorq_s & m1_s & (a2_q[7:0] == CTRL_PORT);
    assign mem_rd_fall = mreq_fall & ~rd_s;
    assign trap_ev     = mem_rd_fall & ~m1_s & trap_addr & ~traps_dis_q;
    assign pageout_ev  = mem_rd_fall & (a2_q == PAGEOUT_ADDR);
    assign force_in    = d2_q[CTRL_FORCE_IN];
    assign force_out   = d2_q[CTRL_FORCE_OUT];

    // A control write in the same cycle as a memory event shadows it entirely.
    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        traps_dis_d = traps_dis_q;
        count_d     = count_q;
        if (ctrl_wr) begin
            wp_d        = d2_q[CTRL_WP];
            traps_dis_d = d2_q[CTRL_TRAPS_DIS];
            if (force_in && !force_out) begin
                state_d = ST_ON;
                if (state_q != ST_ON) count_d = count_q + 4'd1;
            end else if (force_out && !force_in) begin
                state_d = ST_OFF;
            end
        end else if (trap_ev) begin
            count_d = count_q + 4'd1;
            if (state_q == ST_OFF) state_d = ST_ON;
        end else if (pageout_ev) begin
            if (state_q == ST_ON) state_d = ST_EXITING;
        end else if (mreq_rise && state_q == ST_EXITING) begin
            state_d = ST_OFF;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a1_q        <= '0;
            a2_q        <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            state_q     <= ST_OFF;
            wp_q        <= 1'b0;
            traps_dis_q <= 1'b0;
            count_q     <= 4'd0;
        end else begin
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            state_q     <= state_d;
            wp_q        <= wp_d;
            traps_dis_q <= traps_dis_d;
            count_q     <= count_d;
        end
    end

    logic rom_sel;
    logic ram_sel;
    logic io_ok;

    // Chip selects decode the raw pins so they meet the memory access window.
    assign PAGED     = (state_q != ST_OFF);
    assign nZX_ROMCS = PAGED;
    assign rom_sel   = PAGED & ~nMREQ & (A[15:ROM_AW] == '0);
    assign ram_sel   = PAGED & ~nMREQ & (A[15:RAM_AW] == RAM_BASE[15:RAM_AW]);
    assign nROM_CS   = ~rom_sel;
    assign nRAM_CS   = ~ram_sel;
    assign nRAM_WE   = ~(ram_sel & ~nWR & ~wp_q);

    assign io_ok  = ~nIORQ & nM1;
    assign D_OE   = io_ok & ~nRD & (A[7:0] == CTRL_PORT);
    assign LS273  = io_ok & ~nWR & (A[7:0] == FDD_PORT);
    assign nLS244 = ~(io_ok & ~nRD & (A[7:0] == FDD_PORT));
    assign D_OUT  = {count_q, traps_dis_q, wp_q, state_q == ST_EXITING, PAGED};

    logic sync_unused;
    assign sync_unused = &{mreq_s, iorq_fall, iorq_rise, rd_fall, rd_rise,
                           wr_s, wr_rise, m1_fall, m1_rise, d2_q[7:4]};

endmodule
